// File: rtl/fft_reorder_4point.sv
// fft_reorder_4point
//
// Takes the bit-reversed output stream of the SDF FFT stage (X0, X2, X1, X3
// for a 4-point frame) and presents it in natural bin order over a
// valid/ready interface. Frames are stored in a two-bank ping-pong buffer.
// Each sample is written at address bitrev(write count), and samples are read
// back at ascending addresses.
//
// Parameters:
//   n         sample width in bits
//   LOG2_PTS  log2 of the frame length (1..6)
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-high reset (discards partial frames)
//   in_valid   din carries a bit-reversed-order sample this cycle
//   din        FFT output sample
//   out_ready  downstream accepts dout this cycle
//   out_valid  dout carries a natural-order sample
//   dout       reordered sample
//   out_index  natural bin index of dout
//   overflow   sticky; set when an input sample was dropped because the
//              target bank was still full
//   out_last   (only with FFT_REORDER_LAST_EN) high with the last bin of a
//              frame
//
// Optional build macro: FFT_REORDER_LAST_EN adds the out_last port.

module fft_reorder_4point #(
  parameter int n        = 8,
  parameter int LOG2_PTS = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [n-1:0]        din,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [n-1:0]        dout,
  output logic [LOG2_PTS-1:0] out_index,
`ifdef FFT_REORDER_LAST_EN
  output logic                out_last,
`endif
  output logic                overflow
);

  localparam int PTS   = 1 << LOG2_PTS;
  localparam int DEPTH = 2 * PTS;

  function automatic logic [LOG2_PTS-1:0] bitrev(input logic [LOG2_PTS-1:0] a);
    logic [LOG2_PTS-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2_PTS; i++) begin
      r[i] = a[LOG2_PTS-1-i];
    end
    return r;
  endfunction

  // Ping-pong storage. The bank select is the address MSB.
  logic [n-1:0] mem [0:DEPTH-1];

  logic [LOG2_PTS-1:0] wcnt;
  logic                wb;
  logic [LOG2_PTS-1:0] rcnt;
  logic                rb;
  logic [1:0]          bank_full;
  logic [1:0]          full_nxt;

  logic                out_free;
  logic                rd_load_full;
  logic                rd_last;
  logic                rd_release;
  logic                wr_free;
  logic                wr_accept;
  logic                wr_last;
  logic                wr_done;
  logic                rd_avail;
  logic                rd_load;
  logic                rd_clr;
  logic [LOG2_PTS:0]   waddr;
  logic [LOG2_PTS:0]   raddr;

  // The release path is derived only from the registered full flag. That
  // keeps it independent of the write-completion bypass below and avoids a
  // combinational loop. The two paths never apply to the same bank in the
  // same cycle: a release needs bank_full[rb]=1, and the bypass needs it
  // to be 0.
  always_comb begin
    out_free     = !out_valid || out_ready;
    rd_last      = (rcnt == {LOG2_PTS{1'b1}});
    rd_load_full = bank_full[rb] && out_free;
    rd_release   = rd_load_full && rd_last && (rb == wb);

    // A bank that the reader frees this cycle can accept the writer's
    // sample at once.
    wr_free   = !bank_full[wb] || rd_release;
    wr_accept = in_valid && wr_free;
    wr_last   = (wcnt == {LOG2_PTS{1'b1}});
    wr_done   = wr_accept && wr_last;

    // A frame that completes this cycle can be read from at once. The last
    // write always goes to address all-ones, and the first read is from
    // address 0, which was written earlier. This bypass gives the one-cycle
    // latency from the last input sample to the first output sample.
    rd_avail = bank_full[rb] || (wr_done && (wb == rb));
    rd_load  = rd_avail && out_free;
    rd_clr   = rd_load && rd_last;

    waddr = {wb, bitrev(wcnt)};
    raddr = {rb, rcnt};
  end

  always_comb begin
    full_nxt = bank_full;
    if (rd_clr) begin
      full_nxt[rb] = 1'b0;
    end
    if (wr_done) begin
      full_nxt[wb] = 1'b1;
    end
  end

  // The sample memory has no reset. Its stale contents are never read,
  // because a bank is read only after it has been completely rewritten.
  always_ff @(posedge clk) begin
    if (!clear && wr_accept) begin
      mem[waddr] <= din;
    end
  end

  // Write side
  always_ff @(posedge clk) begin
    if (clear) begin
      wcnt     <= '0;
      wb       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wcnt <= wcnt + 1'b1;
        if (wr_last) begin
          wb <= ~wb;
        end
      end
      if (in_valid && !wr_free) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= full_nxt;
    end
  end

  // Read side / output register
  always_ff @(posedge clk) begin
    if (clear) begin
      rcnt      <= '0;
      rb        <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_index <= '0;
    end else if (rd_load) begin
      dout      <= mem[raddr];
      out_index <= rcnt;
      out_valid <= 1'b1;
      rcnt      <= rcnt + 1'b1;
      if (rd_last) begin
        rb <= ~rb;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FFT_REORDER_LAST_EN
  // Follows out_index and therefore holds with dout while the output stalls.
  always_ff @(posedge clk) begin
    if (clear) begin
      out_last <= 1'b0;
    end else if (rd_load) begin
      out_last <= rd_last;
    end
  end
`endif

endmodule

// File: doc/fft_reorder_4point.md
Name: fft_reorder_4point

Overview:
Output-side reader for the SDF 4-point FFT stage. The FFT stage emits bins in bit-reversed order (X0, X2, X1, X3) as one sample per cycle. This block writes each frame into a ping-pong buffer at bit-reversed addresses and reads it back in natural order (X0..X3) over a valid/ready interface. It sits between the FFT pipeline output and downstream consumers.

Parameters:
n, 8, sample width in bits (matches FFT stage data width)
LOG2_PTS, 2, log2 of frame length; frame = 2**LOG2_PTS samples; legal range 1..6

Ports:
clk  input  1  system clock; all state updates on the rising edge
clear  input  1  synchronous, active-high reset
in_valid  input  1  din holds a bit-reversed-order FFT sample this cycle
din  input  n  FFT output sample
out_ready  input  1  downstream accepts dout this cycle
out_valid  output  1  dout holds a natural-order sample
dout  output  n  reordered sample
out_index  output  LOG2_PTS  natural bin index of dout
overflow  output  1  sticky: at least one input sample was dropped

Behaviour:
- Reset. clear high at a rising edge gives out_valid=0, dout=0, out_index=0 and overflow=0. It also clears the write counter, write bank select (wb=0), read counter, read bank select (rb=0) and both bank_full flags. Memory contents are not cleared. clear has priority over every other event, including a frame in progress: partial frames are discarded.
- Storage: two banks, each holding 2**LOG2_PTS words of n bits. Each bank has a bank_full flag.
- Write side (no backpressure):
  - A sample is accepted when in_valid=1 and bank_full[wb]=0 (after release bypass, below).
  - An accepted sample is written to bank wb at address bitrev(wcnt), then wcnt increments.
  - When wcnt wraps from 2**LOG2_PTS-1 to 0: set bank_full[wb] and toggle wb.
  - in_valid=0 holds wcnt. Gaps inside a frame are legal.
  - If in_valid=1 while bank_full[wb]=1, the sample is dropped, wcnt is held and overflow is set. overflow stays set until clear.
- Read side:
  - The output register loads when (bank_full[rb]=1) and (out_valid=0 or out_ready=1).
  - On load: dout = bank rb at address rcnt, out_index = rcnt, out_valid = 1, then rcnt increments.
  - When the word at rcnt = 2**LOG2_PTS-1 is loaded: clear bank_full[rb] and toggle rb.
  - If out_ready=1 and there is nothing to load: out_valid becomes 0.
  - If out_ready=0 and out_valid=1: dout, out_index and out_valid hold.
- Throughput and latency:
  - With out_ready held high, the block sustains one sample per cycle indefinitely.
  - If the last sample of a frame is presented in cycle t, out_valid first goes high in cycle t+1 with index 0. Indices 1, 2, 3 follow in cycles t+2, t+3, t+4.
- Simultaneous events:
  - Release bypass: if the reader clears bank_full[b] in the same cycle the writer targets bank b, the writer sees the bank as free and accepts the sample (no drop).
  - The writer setting bank_full for one bank and the reader clearing it for the other bank in the same cycle are independent.
  - Reader and writer never access the same bank's word in the same cycle.
- Bit reversal: bitrev reverses the LOG2_PTS bits. For LOG2_PTS=2 the mapping is 0->0, 1->2, 2->1, 3->3.

Optional Feature:
Macro: FFT_REORDER_LAST_EN.
- Defined: adds output port out_last (1 bit, reset 0). out_last is registered with dout and is high exactly when out_index = 2**LOG2_PTS-1, giving a frame delimiter for downstream. It holds with dout under stall.
- Undefined: the port does not exist and no extra logic is built. All other behaviour is identical.

Test Plan:
1. Single frame, LOG2_PTS=2, out_ready=1, din 10,20,30,40 in consecutive cycles -> dout 10,30,20,40 with out_index 0,1,2,3, first valid one cycle after the 40 is presented; overflow=0.
2. Back-to-back frames 1..8 continuous, out_ready=1 -> dout 1,3,2,4,5,7,6,8 with no gap between frames; out_valid drops only after the 8.
3. Backpressure: out_ready=0 throughout while frames 1..4, 5..8, 9..12 are presented -> first two frames stored; samples 9..12 dropped; overflow=1. Then out_ready=1 -> dout 1,3,2,4,5,7,6,8.
4. Stall mid-read: out_ready toggles 1,0,0,1,... during a frame -> dout/out_index hold while stalled; no sample lost or duplicated.
5. clear asserted after 2 samples of a frame -> out_valid=0, overflow=0 next cycle; the next full frame 50,60,70,80 reads back 50,70,60,80.
6. With FFT_REORDER_LAST_EN defined, scenario 2 -> out_last high only on dout 4 and 8.
